// File: rtl/timer_ctrl_if.sv
// CPU-side register bus for timer_ctrl: word-offset address, write strobe/data,
// combinational read data and the interrupt line towards hwint.
interface timer_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, output we, output din, input dout, input irq);
    modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_ctrl.sv
// Countdown timer with one-shot / auto-reload modes and a maskable interrupt.
// Reads are zero latency; writes apply at the edge they are presented; no backpressure.
module timer_ctrl #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    timer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    localparam logic [1:0] MODE_AUTO = 2'b01;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    state_t      w_state_nxt;
    logic [31:0] w_count_nxt;
    logic        w_flag_nxt;
    logic        w_en_clr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;

    assign w_wr_ctrl   = bus.we && (bus.addr == 2'd0);
    assign w_wr_preset = bus.we && (bus.addr == 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flag_nxt  = r_irq_flag;
        w_en_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0])
                    w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_ctrl[0]) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // PRESET of 0 lands here too, so it behaves exactly like 1
                    w_count_nxt = 32'd0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (r_ctrl[2:1] == MODE_AUTO) begin
                    w_flag_nxt  = 1'b0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= PRESET_RST;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // A CPU write to CTRL or PRESET acknowledges the interrupt, even on the edge it fires
            r_irq_flag <= (w_wr_ctrl || w_wr_preset) ? 1'b0 : w_flag_nxt;
            if (w_wr_ctrl)
                r_ctrl <= bus.din[3:0];
            else if (w_en_clr)
                r_ctrl[0] <= 1'b0;
            if (w_wr_preset)
                r_preset <= bus.din;
        end
    end

    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            2'd0:    bus.dout = {28'd0, r_ctrl};
            2'd1:    bus.dout = r_preset;
            2'd2:    bus.dout = r_count;
            default: bus.dout = 32'd0;
        endcase
    end

    assign bus.irq = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: reset, one-shot, auto-reload, pause, mask, reset mid-count.
module tb_timer_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_bad;

    timer_ctrl_if bus ();

    timer_ctrl #(.PRESET_RST(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        tick();
        bus.we   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.dout;
    endtask

    logic [31:0] v;

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        bus.addr = 2'd0;
        bus.we   = 1'b1;
        bus.din  = 32'hF;

        // reset overrides a concurrent write
        tick();
        tick();
        reset  = 1'b1;
        bus.we = 1'b0;
        rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
        rd(2'd1, v); chk("rst_preset", v, 32'd0);
        rd(2'd2, v); chk("rst_count", v, 32'd0);
        rd(2'd3, v); chk("rst_rsvd", v, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);

        // one-shot, PRESET=5: irq seven edges after the CTRL write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        tick();
        for (int k = 5; k >= 1; k--) begin
            rd(2'd2, v); chk("os_count", v, k);
            chk("os_irq_low", {31'd0, bus.irq}, 32'd0);
            tick();
        end
        rd(2'd2, v); chk("os_count0", v, 32'd0);
        chk("os_irq_rise", {31'd0, bus.irq}, 32'd1);
        tick();
        rd(2'd0, v); chk("os_en_clr", v, 32'h8);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k % 5 == 4) chk("os_irq_hold", {31'd0, bus.irq}, 32'd1);
        end
        wr(2'd1, 32'd5);
        chk("os_irq_ack", {31'd0, bus.irq}, 32'd0);
        rd(2'd3, v); chk("rsvd_rd", v, 32'd0);

        // auto-reload, PRESET=3: one-cycle pulse every 5 cycles
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            tick();
            chk($sformatf("ar_irq_%0d", k), {31'd0, bus.irq},
                (k >= 5 && (k % 5) == 0) ? 32'd1 : 32'd0);
        end
        wr(2'd0, 32'd0);
        repeat (3) tick();
        chk("ar_stop_irq", {31'd0, bus.irq}, 32'd0);

        // pause: clear EN on the edge COUNT becomes 6
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        repeat (5) tick();
        rd(2'd2, v); chk("pz_count7", v, 32'd7);
        wr(2'd0, 32'h0);
        rd(2'd2, v); chk("pz_count6", v, 32'd6);
        repeat (5) tick();
        rd(2'd2, v); chk("pz_hold", v, 32'd6);
        chk("pz_irq", {31'd0, bus.irq}, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd(2'd2, v); chk("pz_reload", v, 32'd10);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // masked one-shot, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        repeat (4) tick();
        rd(2'd2, v); chk("mk_count0", v, 32'd0);
        chk("mk_irq_masked", {31'd0, bus.irq}, 32'd0);
        tick();
        rd(2'd0, v); chk("mk_en_clr", v, 32'd0);
        wr(2'd0, 32'h8);
        rd(2'd0, v); chk("mk_ctrl", v, 32'h8);
        chk("mk_irq_cleared", {31'd0, bus.irq}, 32'd0);
        repeat (3) tick();
        chk("mk_irq_stays", {31'd0, bus.irq}, 32'd0);

        // reset while COUNT=4 in auto-reload
        wr(2'd1, 32'd6);
        wr(2'd0, 32'hB);
        repeat (4) tick();
        rd(2'd2, v); chk("rm_count4", v, 32'd4);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rd(2'd2, v); chk("rm_count", v, 32'd0);
        rd(2'd0, v); chk("rm_ctrl", v, 32'd0);
        rd(2'd1, v); chk("rm_preset", v, 32'd0);
        chk("rm_irq", {31'd0, bus.irq}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k % 4 == 3) begin
                chk("rm_no_irq", {31'd0, bus.irq}, 32'd0);
                rd(2'd2, v); chk("rm_count_idle", v, 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
